// File: rtl/avlmm_rr_arbiter.sv
// avlmm_rr_arbiter
// Purpose: shares one single-beat Avalon-MM master between two requesters
// (s0, s1) with round-robin arbitration on ties. Reads are tracked in an
// in-order ID FIFO so that returning read data is routed back to the
// requester that issued it. Writes are fire-and-forget.
//
// Ports:
//   Clk_400, SoftReset          - clock, synchronous active-high reset
//   sN_address/read/write/...   - Avalon-MM slave side of requester N (N=0,1)
//   sN_waitrequest              - low only in the cycle requester N is granted
//   sN_readdata/readdatavalid   - routed read data, one-cycle pulse per beat
//   m_*                         - registered Avalon-MM master command, burst 1
//   m_waitrequest/readdata/...  - master side response inputs
//   rd_orphan_err               - sticky: read data seen with nothing outstanding
module avlmm_rr_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 64,
  parameter int MAX_RD = 4
) (
  input  logic                Clk_400,
  input  logic                SoftReset,

  input  logic [ADDR_W-1:0]   s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  output logic                s0_waitrequest,
  output logic [DATA_W-1:0]   s0_readdata,
  output logic                s0_readdatavalid,

  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,

  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [11:0]         m_burstcount,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,

  output logic                rd_orphan_err
);

  // MAX_RD is a power of two, so the pointers wrap naturally and the count
  // needs one extra bit to represent "full".
  localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RD);

  typedef enum logic {IDLE, CMD} state_t;

  state_t              r_state;
  logic                r_lastGrant;
  logic                r_curId;
  logic [ADDR_W-1:0]   r_mAddress;
  logic                r_mRead;
  logic                r_mWrite;
  logic [DATA_W-1:0]   r_mWritedata;
  logic [DATA_W/8-1:0] r_mByteenable;

  logic [MAX_RD-1:0]   r_idFifo;
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_count;

  logic                r_s0Rdv;
  logic                r_s1Rdv;
  logic [DATA_W-1:0]   r_s0Rdata;
  logic [DATA_W-1:0]   r_s1Rdata;
  logic                r_orphan;

  logic                w_rdRoom;
  logic                w_elig0;
  logic                w_elig1;
  logic                w_grantValid;
  logic                w_grantId;
  logic                w_selRead;
  logic                w_selWrite;
  logic [ADDR_W-1:0]   w_selAddress;
  logic [DATA_W-1:0]   w_selWritedata;
  logic [DATA_W/8-1:0] w_selByteenable;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_orphan;
  logic                w_popId;

  // A read is only eligible while the ID FIFO has room; writes never wait on it.
  assign w_rdRoom = (r_count < CNT_MAX);
  assign w_elig0  = s0_write | (s0_read & w_rdRoom);
  assign w_elig1  = s1_write | (s1_read & w_rdRoom);

  // On a tie the requester that did not win last time goes first.
  assign w_grantValid = ~SoftReset & (r_state == IDLE) & (w_elig0 | w_elig1);
  assign w_grantId    = (w_elig0 & w_elig1) ? ~r_lastGrant : w_elig1;

  assign s0_waitrequest = ~(w_grantValid & ~w_grantId);
  assign s1_waitrequest = ~(w_grantValid &  w_grantId);

  // Read together with write is issued as a write only.
  assign w_selWrite      = w_grantId ? s1_write : s0_write;
  assign w_selRead       = (w_grantId ? s1_read : s0_read) & ~w_selWrite;
  assign w_selAddress    = w_grantId ? s1_address : s0_address;
  assign w_selWritedata  = w_grantId ? s1_writedata : s0_writedata;
  assign w_selByteenable = w_grantId ? s1_byteenable : s0_byteenable;

  assign w_accept = (r_state == CMD) & ~m_waitrequest;
  assign w_push   = w_accept & r_mRead;
  assign w_pop    = m_readdatavalid & (r_count != '0);
  assign w_orphan = m_readdatavalid & (r_count == '0);
  assign w_popId  = r_idFifo[r_rdPtr];

  // Arbitration FSM: capture the winner's command in IDLE, hold it in CMD
  // until the slave drops waitrequest, then release the bus for one cycle.
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      r_state       <= IDLE;
      r_lastGrant   <= 1'b1;
      r_curId       <= 1'b0;
      r_mAddress    <= '0;
      r_mRead       <= 1'b0;
      r_mWrite      <= 1'b0;
      r_mWritedata  <= '0;
      r_mByteenable <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_mAddress    <= w_selAddress;
            r_mRead       <= w_selRead;
            r_mWrite      <= w_selWrite;
            r_mWritedata  <= w_selWritedata;
            r_mByteenable <= w_selByteenable;
            r_curId       <= w_grantId;
            r_lastGrant   <= w_grantId;
            r_state       <= CMD;
          end
        end
        CMD: begin
          if (!m_waitrequest) begin
            r_mRead  <= 1'b0;
            r_mWrite <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // In-order ID FIFO of outstanding reads; push and pop in the same cycle
  // move both pointers and leave the count alone.
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      r_idFifo <= '0;
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_idFifo[r_wrPtr] <= r_curId;
        r_wrPtr           <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Return path: popped data is registered toward its owner; readdata holds
  // between beats. Data with no owner is dropped and flagged.
  always_ff @(posedge Clk_400) begin
    if (SoftReset) begin
      r_s0Rdv   <= 1'b0;
      r_s1Rdv   <= 1'b0;
      r_s0Rdata <= '0;
      r_s1Rdata <= '0;
      r_orphan  <= 1'b0;
    end else begin
      r_s0Rdv <= w_pop & ~w_popId;
      r_s1Rdv <= w_pop &  w_popId;
      if (w_pop && !w_popId) begin
        r_s0Rdata <= m_readdata;
      end
      if (w_pop && w_popId) begin
        r_s1Rdata <= m_readdata;
      end
      if (w_orphan) begin
        r_orphan <= 1'b1;
      end
    end
  end

  assign m_address        = r_mAddress;
  assign m_read           = r_mRead;
  assign m_write          = r_mWrite;
  assign m_writedata      = r_mWritedata;
  assign m_byteenable     = r_mByteenable;
  assign m_burstcount     = 12'd1;
  assign s0_readdata      = r_s0Rdata;
  assign s0_readdatavalid = r_s0Rdv;
  assign s1_readdata      = r_s1Rdata;
  assign s1_readdatavalid = r_s1Rdv;
  assign rd_orphan_err    = r_orphan;

endmodule

// File: tb/tb_avlmm_rr_arbiter.sv
// tb_avlmm_rr_arbiter
// Self-checking bench: a transaction-level model (pending command, queue of
// outstanding read owners, per-requester return registers) predicts every
// output each cycle; directed scenarios add literal expectations on top.
module tb_avlmm_rr_arbiter;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int MAX_RD = 4;

  logic              Clk_400 = 1'b0;
  logic              SoftReset = 1'b1;
  logic [ADDR_W-1:0] s0_address = '0, s1_address = '0;
  logic              s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic [DATA_W-1:0] s0_writedata = '0, s1_writedata = '0;
  logic [BE_W-1:0]   s0_byteenable = '0, s1_byteenable = '0;
  logic              s0_waitrequest, s1_waitrequest;
  logic [DATA_W-1:0] s0_readdata, s1_readdata;
  logic              s0_readdatavalid, s1_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic              m_read, m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [BE_W-1:0]   m_byteenable;
  logic [11:0]       m_burstcount;
  logic              m_waitrequest = 1'b0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              rd_orphan_err;

  int nTests = 0;
  int nFail  = 0;

  always #5 Clk_400 = ~Clk_400;

  avlmm_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD)) dut (
    .Clk_400(Clk_400), .SoftReset(SoftReset),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .rd_orphan_err(rd_orphan_err)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, 64'(actual), 64'(expected));
  endtask

  // Behavioural model state: what the master bus is carrying, who owns each
  // outstanding read, and what each requester was last handed.
  logic              mdlBusy = 1'b0;
  logic              mdlIsRead = 1'b0;
  logic              mdlIsWrite = 1'b0;
  logic              mdlId = 1'b0;
  logic [ADDR_W-1:0] mdlAddr = '0;
  logic [DATA_W-1:0] mdlWdata = '0;
  logic [BE_W-1:0]   mdlBe = '0;
  logic              mdlLast = 1'b1;
  bit                mdlIdQ[$];
  logic              mdlRdv[2] = '{1'b0, 1'b0};
  logic [DATA_W-1:0] mdlRdata[2] = '{'0, '0};
  logic              mdlOrphan = 1'b0;

  // Compare every cycle on the falling edge, then advance the model to the
  // state the DUT will hold after the next rising edge.
  always @(negedge Clk_400) begin
    bit e0, e1, win, winner, pid;
    e0 = s0_write || (s0_read && (mdlIdQ.size() < MAX_RD));
    e1 = s1_write || (s1_read && (mdlIdQ.size() < MAX_RD));
    win = !SoftReset && !mdlBusy && (e0 || e1);
    winner = (e0 && e1) ? !mdlLast : e1;

    checkBit("s0_waitrequest", s0_waitrequest, !(win && !winner));
    checkBit("s1_waitrequest", s1_waitrequest, !(win && winner));
    checkBit("m_read", m_read, mdlBusy && mdlIsRead);
    checkBit("m_write", m_write, mdlBusy && mdlIsWrite);
    checkOutput("m_address", 64'(m_address), 64'(mdlAddr));
    checkOutput("m_writedata", m_writedata, mdlWdata);
    checkOutput("m_byteenable", 64'(m_byteenable), 64'(mdlBe));
    checkOutput("m_burstcount", 64'(m_burstcount), 64'd1);
    checkBit("s0_readdatavalid", s0_readdatavalid, mdlRdv[0]);
    checkBit("s1_readdatavalid", s1_readdatavalid, mdlRdv[1]);
    checkOutput("s0_readdata", s0_readdata, mdlRdata[0]);
    checkOutput("s1_readdata", s1_readdata, mdlRdata[1]);
    checkBit("rd_orphan_err", rd_orphan_err, mdlOrphan);

    if (SoftReset) begin
      mdlBusy = 0; mdlIsRead = 0; mdlIsWrite = 0; mdlId = 0;
      mdlAddr = '0; mdlWdata = '0; mdlBe = '0; mdlLast = 1;
      mdlIdQ.delete();
      mdlRdv = '{1'b0, 1'b0}; mdlRdata = '{'0, '0}; mdlOrphan = 0;
    end else begin
      mdlRdv = '{1'b0, 1'b0};
      if (m_readdatavalid) begin
        if (mdlIdQ.size() > 0) begin
          pid = mdlIdQ.pop_front();
          mdlRdata[pid] = m_readdata;
          mdlRdv[pid] = 1'b1;
        end else begin
          mdlOrphan = 1'b1;
        end
      end
      if (mdlBusy) begin
        if (!m_waitrequest) begin
          if (mdlIsRead) mdlIdQ.push_back(mdlId);
          mdlBusy = 1'b0;
        end
      end else if (win) begin
        mdlBusy    = 1'b1;
        mdlId      = winner;
        mdlLast    = winner;
        mdlIsWrite = winner ? s1_write : s0_write;
        mdlIsRead  = (winner ? s1_read : s0_read) && !mdlIsWrite;
        mdlAddr    = winner ? s1_address : s0_address;
        mdlWdata   = winner ? s1_writedata : s0_writedata;
        mdlBe      = winner ? s1_byteenable : s0_byteenable;
      end
    end
  end

  task automatic cycle();
    @(posedge Clk_400);
    #1;
  endtask

  task automatic applyStimulus();
    SoftReset       = ($urandom_range(0, 199) == 0);
    s0_read         = ($urandom_range(0, 1) == 1);
    s0_write        = ($urandom_range(0, 4) == 0);
    s1_read         = ($urandom_range(0, 1) == 1);
    s1_write        = ($urandom_range(0, 4) == 0);
    s0_address      = ADDR_W'($urandom);
    s1_address      = ADDR_W'($urandom);
    s0_writedata    = {$urandom, $urandom};
    s1_writedata    = {$urandom, $urandom};
    s0_byteenable   = BE_W'($urandom);
    s1_byteenable   = BE_W'($urandom);
    m_waitrequest   = ($urandom_range(0, 2) == 0);
    m_readdata      = {$urandom, $urandom};
    if (mdlIdQ.size() > 0) m_readdatavalid = ($urandom_range(0, 9) < 3);
    else                   m_readdatavalid = ($urandom_range(0, 49) == 0);
  endtask

  initial begin
    int grants;
    logic [DATA_W-1:0] got0[$];
    logic [DATA_W-1:0] got1[$];

    // Reset state
    repeat (3) cycle();
    @(negedge Clk_400);
    checkBit("rst_s0_wait", s0_waitrequest, 1'b1);
    checkBit("rst_s1_wait", s1_waitrequest, 1'b1);
    checkBit("rst_m_read", m_read, 1'b0);
    checkBit("rst_orphan", rd_orphan_err, 1'b0);
    cycle(); SoftReset = 1'b0;

    // Tie after reset: s0 first, then s1 two cycles later
    cycle();
    s0_write = 1; s0_address = 26'h10; s0_writedata = 64'h1111; s0_byteenable = 8'hFF;
    s1_write = 1; s1_address = 26'h20; s1_writedata = 64'h2222; s1_byteenable = 8'h0F;
    @(negedge Clk_400);
    checkBit("tie_s0_grant", s0_waitrequest, 1'b0);
    checkBit("tie_s1_wait", s1_waitrequest, 1'b1);
    cycle(); s0_write = 0;
    @(negedge Clk_400);
    checkBit("tie_m_write0", m_write, 1'b1);
    checkOutput("tie_addr0", 64'(m_address), 64'h10);
    cycle();
    @(negedge Clk_400);
    checkBit("tie_m_write_gap", m_write, 1'b0);
    checkBit("tie_s1_grant", s1_waitrequest, 1'b0);
    cycle(); s1_write = 0;
    @(negedge Clk_400);
    checkOutput("tie_addr1", 64'(m_address), 64'h20);
    checkOutput("tie_be1", 64'(m_byteenable), 64'h0F);
    cycle();

    // Backpressure on an s1 read
    s1_read = 1; s1_address = 26'h3; m_waitrequest = 1;
    @(negedge Clk_400);
    checkBit("bp_s1_grant", s1_waitrequest, 1'b0);
    cycle(); s1_read = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk_400);
      checkBit("bp_m_read_held", m_read, 1'b1);
      checkOutput("bp_addr_held", 64'(m_address), 64'h3);
      cycle();
    end
    m_waitrequest = 0;
    @(negedge Clk_400);
    checkBit("bp_m_read_last", m_read, 1'b1);
    cycle();
    @(negedge Clk_400);
    checkBit("bp_m_read_clear", m_read, 1'b0);
    cycle(); m_readdatavalid = 1; m_readdata = 64'hDEAD;
    @(negedge Clk_400);
    checkBit("bp_rdv_early", s1_readdatavalid, 1'b0);
    cycle(); m_readdatavalid = 0;
    @(negedge Clk_400);
    checkBit("bp_s1_rdv", s1_readdatavalid, 1'b1);
    checkOutput("bp_s1_data", s1_readdata, 64'hDEAD);
    cycle();
    @(negedge Clk_400);
    checkOutput("bp_s1_hold", s1_readdata, 64'hDEAD);

    // Outstanding limit: four reads accepted, fifth blocked, writes still go
    cycle(); s0_read = 1; s0_address = 26'h100;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk_400);
      if (!s0_waitrequest) grants++;
      cycle();
      s0_address = 26'h100 + ADDR_W'(grants);
    end
    checkOutput("lim_grants", 64'(grants), 64'd4);
    @(negedge Clk_400);
    checkBit("lim_s0_blocked", s0_waitrequest, 1'b1);
    cycle(); s1_write = 1; s1_address = 26'h55;
    @(negedge Clk_400);
    checkBit("lim_s1_write_grant", s1_waitrequest, 1'b0);
    checkBit("lim_s0_still_blocked", s0_waitrequest, 1'b1);
    cycle(); s1_write = 0;
    @(negedge Clk_400);
    checkOutput("lim_write_addr", 64'(m_address), 64'h55);
    cycle(); m_readdatavalid = 1; m_readdata = 64'hA1;
    @(negedge Clk_400);
    checkBit("lim_blocked_on_pop", s0_waitrequest, 1'b1);
    cycle(); m_readdatavalid = 0;
    @(negedge Clk_400);
    checkBit("lim_fifth_grant", s0_waitrequest, 1'b0);
    checkOutput("lim_ret_data", s0_readdata, 64'hA1);
    cycle(); s0_read = 0;
    @(negedge Clk_400);
    checkBit("lim_fifth_read", m_read, 1'b1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1; m_readdata = 64'hB0 + 64'(i);
      cycle();
    end
    m_readdatavalid = 0;
    cycle(); cycle();

    // Interleaved routing with push and pop in the same cycle
    for (int i = 1; i <= 12; i++) begin
      s0_read = (i == 1) || (i == 7);
      s1_read = (i == 3) || (i == 5);
      s0_address = 26'h200 + ADDR_W'(i);
      s1_address = 26'h300 + ADDR_W'(i);
      m_readdatavalid = (i == 4) || (i == 6) || (i == 8) || (i == 9);
      m_readdata = (i == 4) ? 64'd1 : (i == 6) ? 64'd2 : (i == 8) ? 64'd3 : (i == 9) ? 64'd4 : 64'd0;
      @(negedge Clk_400);
      if (s0_readdatavalid) got0.push_back(s0_readdata);
      if (s1_readdatavalid) got1.push_back(s1_readdata);
      cycle();
    end
    s0_read = 0; s1_read = 0; m_readdatavalid = 0;
    checkOutput("rt_s0_count", 64'(got0.size()), 64'd2);
    checkOutput("rt_s1_count", 64'(got1.size()), 64'd2);
    checkOutput("rt_s0_first", (got0.size() > 0) ? got0[0] : '1, 64'd1);
    checkOutput("rt_s0_second", (got0.size() > 1) ? got0[1] : '1, 64'd4);
    checkOutput("rt_s1_first", (got1.size() > 0) ? got1[0] : '1, 64'd2);
    checkOutput("rt_s1_second", (got1.size() > 1) ? got1[1] : '1, 64'd3);
    @(negedge Clk_400);
    checkBit("rt_no_orphan", rd_orphan_err, 1'b0);

    // Orphan read data
    cycle(); m_readdatavalid = 1; m_readdata = 64'hBAD;
    cycle(); m_readdatavalid = 0;
    @(negedge Clk_400);
    checkBit("orph_flag", rd_orphan_err, 1'b1);
    checkBit("orph_no_s0_rdv", s0_readdatavalid, 1'b0);
    checkBit("orph_no_s1_rdv", s1_readdatavalid, 1'b0);
    repeat (3) cycle();
    @(negedge Clk_400);
    checkBit("orph_sticky", rd_orphan_err, 1'b1);
    cycle(); SoftReset = 1;
    cycle();
    @(negedge Clk_400);
    checkBit("orph_cleared", rd_orphan_err, 1'b0);
    cycle(); SoftReset = 0;

    // Reset while a write is stuck in CMD with one read outstanding
    cycle(); s0_read = 1; s0_address = 26'h40;
    cycle(); s0_read = 0;
    cycle(); s1_write = 1; s1_address = 26'h41; m_waitrequest = 1;
    @(negedge Clk_400);
    checkBit("rc_s1_grant", s1_waitrequest, 1'b0);
    cycle(); s1_write = 0;
    @(negedge Clk_400);
    checkBit("rc_m_write", m_write, 1'b1);
    cycle(); SoftReset = 1;
    cycle();
    @(negedge Clk_400);
    checkBit("rc_m_write_clr", m_write, 1'b0);
    checkBit("rc_m_read_clr", m_read, 1'b0);
    checkBit("rc_s0_wait", s0_waitrequest, 1'b1);
    checkBit("rc_s1_wait", s1_waitrequest, 1'b1);
    cycle(); SoftReset = 0; m_waitrequest = 0;
    cycle(); m_readdatavalid = 1; m_readdata = 64'h77;
    cycle(); m_readdatavalid = 0;
    @(negedge Clk_400);
    checkBit("rc_late_data_orphan", rd_orphan_err, 1'b1);
    checkBit("rc_late_no_rdv", s0_readdatavalid, 1'b0);
    cycle(); SoftReset = 1;
    cycle(); SoftReset = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle();
      applyStimulus();
    end
    cycle();
    SoftReset = 1;
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0; m_readdatavalid = 0;
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/avlmm_rr_arbiter.md
AVLMM_RR_ARBITER -- requirements
Module: avlmm_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 26, Avalon word address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_RD, default 4, maximum outstanding reads (power of 2, 2..16).
REQ-004 SHALL have port Clk_400, in, 1: the only clock.
REQ-005 SHALL have port SoftReset, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have requester ports sN_address/in/ADDR_W, sN_read/in/1, sN_write/in/1, sN_writedata/in/DATA_W, sN_byteenable/in/DATA_W/8, for N=0,1.
REQ-007 SHALL have requester ports sN_waitrequest/out/1, sN_readdata/out/DATA_W, sN_readdatavalid/out/1, for N=0,1.
REQ-008 SHALL have master ports m_address/out/ADDR_W, m_read/out/1, m_write/out/1, m_writedata/out/DATA_W, m_byteenable/out/DATA_W/8, m_burstcount/out/12.
REQ-009 SHALL have master ports m_waitrequest/in/1, m_readdata/in/DATA_W, m_readdatavalid/in/1.
REQ-010 SHALL have port rd_orphan_err, out, 1: sticky flag for read data arriving with no outstanding read.

Function
REQ-011 SHALL share one Avalon-MM master between two requesters, single-beat only; m_burstcount SHALL be constant 1.
REQ-012 SHALL use FSM states IDLE and CMD.
REQ-013 In IDLE, requester N is eligible when sN_write=1, or when sN_read=1 and outstanding count < MAX_RD.
REQ-014 In IDLE, with any eligible requester, the grant SHALL go to the one eligible requester, or on a tie to the requester not equal to last_grant.
REQ-015 On grant, the command SHALL be registered into the m_* outputs, sN_waitrequest of the winner SHALL be 0 in that same cycle, last_grant SHALL become the winner, and the FSM SHALL go to CMD.
REQ-016 sN_waitrequest SHALL be 1 in every other cycle, including all of CMD.
REQ-017 If a requester asserts read and write together, it SHALL be treated as a write; m_read SHALL be 0.
REQ-018 In CMD, m_read/m_write SHALL stay asserted with all m_* fields held stable while m_waitrequest=1.
REQ-019 In CMD, in the first cycle with m_waitrequest=0, m_read and m_write SHALL be cleared in the next cycle and the FSM SHALL return to IDLE.
REQ-020 A command accepted in cycle T SHALL allow the next grant no earlier than cycle T+1; peak rate is one command per 2 cycles.
REQ-021 Each accepted read (CMD, m_read=1, m_waitrequest=0) SHALL push the winner ID into a MAX_RD-deep in-order ID FIFO and increment the outstanding count.
REQ-022 Each m_readdatavalid=1 SHALL pop the FIFO head ID.
REQ-023 After a pop, m_readdata SHALL be registered to sID_readdata and sID_readdatavalid SHALL be 1 for exactly one cycle, one cycle later.
REQ-024 sN_readdata SHALL hold its last value when sN_readdatavalid=0.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged and keep FIFO order correct, including at pointer wrap.
REQ-026 When the count = MAX_RD, reads SHALL be ineligible and writes SHALL still be granted.
REQ-027 If m_readdatavalid=1 while the FIFO is empty, the data SHALL be dropped, no sN_readdatavalid SHALL assert, and rd_orphan_err SHALL set and stay set until reset.
REQ-028 Writes SHALL not be tracked; there is no write response.

Reset
REQ-029 While SoftReset=1 the FSM SHALL go to IDLE, the FIFO and count SHALL clear, last_grant SHALL be 1 (requester 0 wins the first tie), and rd_orphan_err SHALL be 0.
REQ-030 While SoftReset=1, m_read, m_write, sN_readdatavalid, m_address, m_writedata, m_byteenable and sN_readdata SHALL be 0, and sN_waitrequest SHALL be 1.
REQ-031 Reset mid-transaction SHALL abandon the in-flight command and outstanding reads; read data returning after reset SHALL be treated as orphan (REQ-027).

Verification
REQ-032 Tie after reset: s0 and s1 write together, addr 0x10 and 0x20, m_waitrequest=0. Required: s0 granted first, m_address=0x10 then 0x20, each write 1 cycle, s1_waitrequest low 2 cycles after s0's.
REQ-033 Backpressure: s1 read of 0x3, m_waitrequest high 5 cycles. Required: m_read held 6 cycles with address stable, then readdata 0xDEAD returned on s1_readdatavalid 1 cycle after m_readdatavalid.
REQ-034 Outstanding limit (MAX_RD=4): s0 issues 5 reads with no returns. Required: 4 accepted; 5th blocked with s0_waitrequest=1; an s1 write is still granted; after 1 return the 5th read is issued.
REQ-035 Interleaved routing: reads ordered s0,s1,s1,s0 return data 1,2,3,4. Required: s0 receives 1,4 and s1 receives 2,3; a push and pop in the same cycle keeps the count correct.
REQ-036 Orphan: m_readdatavalid pulse with no outstanding reads. Required: no sN_readdatavalid, rd_orphan_err=1 until SoftReset.
REQ-037 Reset in CMD with m_waitrequest=1. Required: next cycle m_read=m_write=0, both waitrequests=1, count=0.
